refclk_switch_ctrl: RTL and testbench
=====================================

# refclk_switch_ctrl

- Sequences the handover of the FOCT reference clock from the on-board standard clock to the external PLL.
- Monitors PLL lock and, optionally, the external reference frequency; falls back to the standard clock on any fault.
- Retries a bounded number of times, then locks out.
- Output `ClkStart` drives the reference-clock select mux: 0 = standard, 1 = external PLL. The block runs entirely in the 100 MHz system domain.

## Interface
Parameters:
- `SETTLE_CYC`, 1000: lock-stable cycles required before checking/switching.
- `LOCK_TMO_CYC`, 200000: maximum cycles in WAIT_LOCK.
- `WIN_CYC`, 10000: frequency measurement window, in Clk_100M cycles.
- `CNT_MIN`, 995: minimum valid Ext_Ref rising edges per window.
- `CNT_MAX`, 1005: maximum valid Ext_Ref rising edges per window.
- `HOLDOFF_CYC`, 100000: wait in FAULT before retry.
- `MAX_RETRY`, 3: consecutive faults before LOCKOUT (1..7).

Ports:
- `Clk_100M` in 1: system clock. One clock only.
- `SYS_START` in 1: asynchronous active-low reset.
- `Enable` in 1: request switch to external PLL.
- `Force_Std` in 1: force standard clock; highest priority.
- `PLL_Lock` in 1: external PLL lock, asynchronous.
- `Ext_Ref` in 1: external reference, ≤20 MHz, asynchronous.
- `ClkStart` out 1: mux select, registered.
- `Clk_Fault` out 1: one-cycle pulse on entry to FAULT.
- `Lockout` out 1: high in LOCKOUT.
- `Retry_Cnt` out 3: consecutive fault count.
- `State` out 3: current state code.

## Operation
- `PLL_Lock` and `Ext_Ref` each pass through a 2-FF synchronizer (`lock_s`, `ref_s`). A rising edge of `ref_s` increments a 16-bit saturating edge counter.
- All outputs reset to 0; state resets to IDLE.
- States: IDLE=0, WAIT_LOCK=1, SETTLE=2, CHECK=3, RUN=4, FAULT=5, LOCKOUT=6.
- `Force_Std`=1 in any state: IDLE next cycle, `ClkStart`=0, `Retry_Cnt` cleared. This is the only exit from LOCKOUT besides reset.
- IDLE → WAIT_LOCK when `Enable`=1.
- WAIT_LOCK:
  - `lock_s`=1 → SETTLE, settle counter cleared.
  - `LOCK_TMO_CYC` cycles elapsed → FAULT.
- SETTLE:
  - `lock_s`=0 → FAULT.
  - After `SETTLE_CYC` cycles → CHECK.
- CHECK: one full window.
  - At window end, count in [CNT_MIN, CNT_MAX] inclusive → RUN.
  - Count out of range → FAULT.
  - `lock_s`=0 → FAULT.
- RUN:
  - `ClkStart`=1; `Retry_Cnt` cleared on entry.
  - `lock_s`=0 → FAULT.
  - Windows restart back-to-back; any out-of-range window → FAULT.
  - `Enable`=0 → IDLE.
- FAULT:
  - On entry: `Clk_Fault` pulses for 1 cycle; `ClkStart`=0; `Retry_Cnt` increments, saturating at 7.
  - If the new count equals `MAX_RETRY` → LOCKOUT.
  - Otherwise wait `HOLDOFF_CYC` cycles, then → WAIT_LOCK, or → IDLE if `Enable`=0.
- LOCKOUT: `ClkStart`=0, `Lockout`=1; holds until reset or `Force_Std`.
- Window and edge counters clear on CHECK entry and at each window boundary. An edge on the boundary cycle counts toward the new window.
- Simultaneous window end and lock loss: lock loss wins (FAULT).

## Timing
- `PLL_Lock` falling to `ClkStart` low: ≤3 cycles (2 sync + 1 register).
- `Force_Std` to `ClkStart` low: 1 cycle, since `Force_Std` is synchronous to Clk_100M.
- Lock asserted to `ClkStart` high: 2 + `SETTLE_CYC` + `WIN_CYC` + 1 cycles with check enabled, 2 + `SETTLE_CYC` + 1 without.
- `Clk_Fault` is asserted in the first FAULT cycle only.
- `SYS_START` low mid-operation: all outputs 0 asynchronously; restart from IDLE.

## Configuration
- `EPLL_FREQ_CHECK_EN` defined:
  - CHECK state is present and RUN performs continuous window checks.
  - Edge and window counters are instantiated.
- Undefined:
  - Counters and the CHECK state are removed; SETTLE → RUN directly.
  - RUN faults on lock loss only.
  - `Ext_Ref` is ignored.
  - State code 3 never appears.

## Test plan
- Reset with `Enable`=1 and `PLL_Lock` held at 1, 10 MHz `Ext_Ref`: `ClkStart` rises 11003 cycles after reset release (macro on) or 1003 (macro off). `Retry_Cnt`=0.
- In RUN, drop `PLL_Lock`: `ClkStart`=0 within 3 cycles. `Clk_Fault` 1-cycle pulse, `Retry_Cnt`=1, WAIT_LOCK after 100000 cycles.
- Macro on, `Ext_Ref`=9.9 MHz (990 edges per window): CHECK → FAULT at window end. Three repeats → LOCKOUT, `Lockout`=1, `Retry_Cnt`=3.
- `PLL_Lock` never asserts: FAULT after 200000 cycles in WAIT_LOCK.
- In LOCKOUT, pulse `Force_Std` for 1 cycle: IDLE, `Lockout`=0, `Retry_Cnt`=0. With `Enable`=1, the next cycle is WAIT_LOCK.
- Assert `SYS_START`=0 during SETTLE: all outputs 0 immediately, `State`=0.

Source files
------------

// File: rtl/refclk_switch_ctrl.sv
// refclk_switch_ctrl
// Sequences the handover of the FOCT reference clock from the on-board
// standard clock to the external PLL, watches PLL lock (and optionally the
// Ext_Ref frequency), and falls back to the standard clock on any fault.
// After MAX_RETRY consecutive faults the block locks out until reset or
// Force_Std. Single clock domain: Clk_100M. SYS_START is the async active-low
// reset.
//
// Optional feature macro: EPLL_FREQ_CHECK_EN
//   defined   : CHECK state present, Ext_Ref counted over WIN_CYC windows,
//               RUN keeps checking windows back-to-back.
//   undefined : no counters, SETTLE goes straight to RUN, Ext_Ref ignored.
module refclk_switch_ctrl #(
  parameter int unsigned SETTLE_CYC   = 1000,
  parameter int unsigned LOCK_TMO_CYC = 200000,
  parameter int unsigned WIN_CYC      = 10000,
  parameter int unsigned CNT_MIN      = 995,
  parameter int unsigned CNT_MAX      = 1005,
  parameter int unsigned HOLDOFF_CYC  = 100000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       Clk_100M,
  input  logic       SYS_START,
  input  logic       Enable,
  input  logic       Force_Std,
  input  logic       PLL_Lock,
  input  logic       Ext_Ref,
  output logic       ClkStart,
  output logic       Clk_Fault,
  output logic       Lockout,
  output logic [2:0] Retry_Cnt,
  output logic [2:0] State
);

  // State codes are visible on the State port, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5,
    ST_LOCKOUT   = 3'd6
  } state_t;

  // One shared dwell timer serves SETTLE, WAIT_LOCK timeout and FAULT
  // holdoff; it only has to reach the largest of the three.
  localparam int unsigned TMR_MAX_A = (SETTLE_CYC > LOCK_TMO_CYC) ? SETTLE_CYC : LOCK_TMO_CYC;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > HOLDOFF_CYC) ? TMR_MAX_A : HOLDOFF_CYC;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [TMR_W-1:0] r_tmr;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             r_clk_start;
  logic             r_clk_fault;
  logic             r_lockout;
  logic [2:0]       r_retry;

  logic             w_state_chg;
  logic             w_settle_done;
  logic             w_lock_tmo;
  logic             w_holdoff_done;
  logic             w_retry_max;
  logic             w_fault_entry;
  logic             w_run_entry;

  // ---------------------------------------------------------------------------
  // PLL_Lock synchronizer
  // ---------------------------------------------------------------------------
  // Two-flop synchronizer bringing the asynchronous PLL lock into Clk_100M.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      // NOTE: synchronizer flops are reset too, so lock_s reads "unlocked"
      // until two real samples have been taken after reset release.
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value
      // of its source; blocking here would collapse the two stages into one.
      r_lock_meta <= PLL_Lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional Ext_Ref frequency window check
  // ---------------------------------------------------------------------------
`ifdef EPLL_FREQ_CHECK_EN
  localparam int unsigned WIN_W = $clog2(WIN_CYC + 1);

  logic             r_ref_meta;
  logic             r_ref_s;
  logic             r_ref_d;
  logic [WIN_W-1:0] r_win_cnt;
  logic [15:0]      r_edge_cnt;
  logic             w_ref_rise;
  logic             w_win_active;
  logic             w_check_entry;
  logic             w_win_end;
  logic             w_cnt_ok;
  logic             w_win_bad;

  assign w_ref_rise    = r_ref_s & ~r_ref_d;
  assign w_win_active  = (r_state == ST_CHECK) || (r_state == ST_RUN);
  assign w_check_entry = (w_state_nx == ST_CHECK) && (r_state != ST_CHECK);
  assign w_win_end     = (r_win_cnt == WIN_W'(WIN_CYC - 1));
  assign w_cnt_ok      = (r_edge_cnt >= 16'(CNT_MIN)) && (r_edge_cnt <= 16'(CNT_MAX));
  assign w_win_bad     = w_win_active && w_win_end && !w_cnt_ok;

  // Two-flop synchronizer for Ext_Ref plus a delay flop for edge detection.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_ref_meta <= 1'b0;
      r_ref_s    <= 1'b0;
      r_ref_d    <= 1'b0;
    end else begin
      r_ref_meta <= Ext_Ref;
      r_ref_s    <= r_ref_meta;
      r_ref_d    <= r_ref_s;
    end
  end

  // Window and edge counters: cleared on CHECK entry, restarted at every
  // window boundary; a rising edge seen on the boundary cycle opens the next
  // window's count.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (w_check_entry || !w_win_active) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (w_win_end) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= {15'd0, w_ref_rise};
    end else begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      if (w_ref_rise && (r_edge_cnt != 16'hFFFF)) begin
        r_edge_cnt <= r_edge_cnt + 16'd1;
      end
    end
  end
`else
  // Frequency check compiled out: Ext_Ref and the window parameters are
  // intentionally left without a load.
  logic w_unused_freq;
  assign w_unused_freq = Ext_Ref ^ (^(WIN_CYC ^ CNT_MIN ^ CNT_MAX));
`endif

  // ---------------------------------------------------------------------------
  // Dwell timer
  // ---------------------------------------------------------------------------
  assign w_state_chg    = (w_state_nx != r_state);
  assign w_settle_done  = (r_tmr == TMR_W'(SETTLE_CYC - 1));
  assign w_lock_tmo     = (r_tmr == TMR_W'(LOCK_TMO_CYC - 1));
  assign w_holdoff_done = (r_tmr == TMR_W'(HOLDOFF_CYC - 1));
  assign w_retry_max    = (r_retry == 3'(MAX_RETRY));

  // Counts cycles spent in the current state; restarts on every transition.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_tmr <= '0;
    end else if (w_state_chg) begin
      r_tmr <= '0;
    end else if (r_tmr != TMR_W'(TMR_MAX)) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic. Force_Std overrides everything; within a state, lock
  // loss is checked before any window verdict so it wins a tie.
  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nx and no
    // latch is inferred.
    w_state_nx = r_state;
    if (Force_Std) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Enable) w_state_nx = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s)        w_state_nx = ST_SETTLE;
          else if (w_lock_tmo) w_state_nx = ST_FAULT;
        end
        ST_SETTLE: begin
          if (!r_lock_s) begin
            w_state_nx = ST_FAULT;
          end else if (w_settle_done) begin
`ifdef EPLL_FREQ_CHECK_EN
            w_state_nx = ST_CHECK;
`else
            w_state_nx = ST_RUN;
`endif
          end
        end
`ifdef EPLL_FREQ_CHECK_EN
        ST_CHECK: begin
          if (!r_lock_s)      w_state_nx = ST_FAULT;
          else if (w_win_end) w_state_nx = w_cnt_ok ? ST_RUN : ST_FAULT;
        end
`endif
        ST_RUN: begin
          if (!r_lock_s)      w_state_nx = ST_FAULT;
`ifdef EPLL_FREQ_CHECK_EN
          else if (w_win_bad) w_state_nx = ST_FAULT;
`endif
          else if (!Enable)   w_state_nx = ST_IDLE;
        end
        ST_FAULT: begin
          // Retry_Cnt was bumped on entry, so the first FAULT cycle already
          // sees the new count.
          if (w_retry_max)         w_state_nx = ST_LOCKOUT;
          else if (w_holdoff_done) w_state_nx = Enable ? ST_WAIT_LOCK : ST_IDLE;
        end
        ST_LOCKOUT: begin
          w_state_nx = ST_LOCKOUT;
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and retry counter
  // ---------------------------------------------------------------------------
  assign w_fault_entry = (w_state_nx == ST_FAULT) && (r_state != ST_FAULT);
  assign w_run_entry   = (w_state_nx == ST_RUN) && (r_state != ST_RUN);

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register, glitch-free at the mux select.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_clk_start <= 1'b0;
      r_clk_fault <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_clk_start <= (w_state_nx == ST_RUN);
      r_clk_fault <= w_fault_entry;
      r_lockout   <= (w_state_nx == ST_LOCKOUT);
    end
  end

  // Consecutive fault count: cleared by Force_Std or a successful RUN entry,
  // incremented (saturating at 7) on each FAULT entry.
  always_ff @(posedge Clk_100M or negedge SYS_START) begin
    if (!SYS_START) begin
      r_retry <= 3'd0;
    end else if (Force_Std || w_run_entry) begin
      r_retry <= 3'd0;
    end else if (w_fault_entry && (r_retry != 3'd7)) begin
      r_retry <= r_retry + 3'd1;
    end
  end

  assign ClkStart  = r_clk_start;
  assign Clk_Fault = r_clk_fault;
  assign Lockout   = r_lockout;
  assign Retry_Cnt = r_retry;
  assign State     = r_state;

endmodule

// File: tb/tb_refclk_switch_ctrl.sv
// Self-checking bench for refclk_switch_ctrl. Expected cycle positions are
// derived from the handover rules (2-flop sync, dwell lengths, window
// length) with plain arithmetic; randomized lock-drop / lock-return delays
// and Ext_Ref periods exercise the timing.
module tb_refclk_switch_ctrl;

  localparam int unsigned SETTLE = 20;
  localparam int unsigned TMO    = 300;
  localparam int unsigned WIN    = 100;
  localparam int unsigned CMIN   = 9;
  localparam int unsigned CMAX   = 11;
  localparam int unsigned HOLD   = 150;
  localparam int unsigned MAXR   = 3;

`ifdef EPLL_FREQ_CHECK_EN
  localparam int LAT = SETTLE + WIN;  // SETTLE entry to RUN entry
`else
  localparam int LAT = SETTLE;
`endif
  // Lock first sampled at edge 1 -> lock_s at edge 2 -> SETTLE at edge 3.
  localparam int RUN_DLY = 3 + LAT;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_SETTLE = 3'd2,
                         S_CHECK = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5,
                         S_LOCK = 3'd6;

  logic       Clk_100M  = 1'b0;
  logic       SYS_START = 1'b0;
  logic       Enable    = 1'b0;
  logic       Force_Std = 1'b0;
  logic       PLL_Lock  = 1'b0;
  logic       Ext_Ref   = 1'b0;
  logic       ClkStart;
  logic       Clk_Fault;
  logic       Lockout;
  logic [2:0] Retry_Cnt;
  logic [2:0] State;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retry = 0;
  int ref_half_ns = 50;  // 10 MHz -> 10 edges per 100-cycle window

  refclk_switch_ctrl #(
    .SETTLE_CYC  (SETTLE),
    .LOCK_TMO_CYC(TMO),
    .WIN_CYC     (WIN),
    .CNT_MIN     (CMIN),
    .CNT_MAX     (CMAX),
    .HOLDOFF_CYC (HOLD),
    .MAX_RETRY   (MAXR)
  ) dut (
    .Clk_100M (Clk_100M),
    .SYS_START(SYS_START),
    .Enable   (Enable),
    .Force_Std(Force_Std),
    .PLL_Lock (PLL_Lock),
    .Ext_Ref  (Ext_Ref),
    .ClkStart (ClkStart),
    .Clk_Fault(Clk_Fault),
    .Lockout  (Lockout),
    .Retry_Cnt(Retry_Cnt),
    .State    (State)
  );

  initial forever #5 Clk_100M = ~Clk_100M;
  initial forever #(ref_half_ns) Ext_Ref = ~Ext_Ref;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges and sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge Clk_100M);
    #1;
  endtask

  function automatic int bump_retry(input int r);
    return (r < 7) ? r + 1 : 7;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    SYS_START = 1'b0; Enable = 1'b1; PLL_Lock = 1'b1; Force_Std = 1'b0;
    step(3);
    n_checks++;
    if ({ClkStart, Clk_Fault, Lockout, Retry_Cnt, State} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {ClkStart, Clk_Fault, Lockout, Retry_Cnt, State});
    end
    SYS_START = 1'b1;
    step(1);
    n_checks++;
    if (State !== S_WAIT) begin
      n_errors++; $display("FAIL reset_edge1_state: got %0d expected %0d", State, S_WAIT);
    end
    step(1);
    n_checks++;
    if (State !== S_WAIT) begin
      n_errors++; $display("FAIL reset_edge2_state: got %0d expected %0d", State, S_WAIT);
    end
    step(1);
    n_checks++;
    if (State !== S_SETTLE) begin
      n_errors++; $display("FAIL reset_edge3_state: got %0d expected %0d", State, S_SETTLE);
    end
    n = 3;
    while ((ClkStart !== 1'b1) && (n < RUN_DLY + 50)) begin
      step(1);
      n++;
    end
    n_checks++;
    if (n != RUN_DLY) begin
      n_errors++; $display("FAIL reset_to_clkstart: got %0d cycles expected %0d", n, RUN_DLY);
    end
    n_checks++;
    if ({State, Retry_Cnt} !== {S_RUN, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_run: got state %0d retry %0d expected %0d 0", State, Retry_Cnt, S_RUN);
    end
    exp_retry = 0;
  endtask

  // ---------------------------------------------------------------------------
  // From RUN: drop lock at a random time, expect FAULT + holdoff, then return
  // lock at a random time and expect RUN again.
  task automatic test_lock_drop();
    int r;
    step($urandom_range(0, 20));
    PLL_Lock = 1'b0;
    step(2);
    n_checks++;
    if ({ClkStart, State} !== {1'b1, S_RUN}) begin
      n_errors++; $display("FAIL drop_early: clkstart %0d state %0d expected 1 %0d", ClkStart, State, S_RUN);
    end
    step(1);
    exp_retry = bump_retry(exp_retry);
    n_checks++;
    if ({ClkStart, Clk_Fault, State, Retry_Cnt} !== {1'b0, 1'b1, S_FAULT, 3'(exp_retry)}) begin
      n_errors++;
      $display("FAIL drop_fault: clkstart %0d fault %0d state %0d retry %0d expected 0 1 %0d %0d",
               ClkStart, Clk_Fault, State, Retry_Cnt, S_FAULT, exp_retry);
    end
    step(1);
    n_checks++;
    if ({Clk_Fault, State} !== {1'b0, S_FAULT}) begin
      n_errors++; $display("FAIL drop_pulse_width: fault %0d state %0d expected 0 %0d", Clk_Fault, State, S_FAULT);
    end
    step(HOLD - 2);
    n_checks++;
    if (State !== S_FAULT) begin
      n_errors++; $display("FAIL holdoff_end: state %0d expected %0d", State, S_FAULT);
    end
    step(1);
    n_checks++;
    if (State !== S_WAIT) begin
      n_errors++; $display("FAIL holdoff_exit: state %0d expected %0d", State, S_WAIT);
    end
    r = $urandom_range(0, 15);
    step(r);
    PLL_Lock = 1'b1;
    step(RUN_DLY - 1);
    n_checks++;
    if (ClkStart !== 1'b0) begin
      n_errors++; $display("FAIL relock_early: clkstart %0d expected 0 (delay %0d)", ClkStart, r);
    end
    step(1);
    exp_retry = 0;
    n_checks++;
    if ({ClkStart, State, Retry_Cnt} !== {1'b1, S_RUN, 3'd0}) begin
      n_errors++;
      $display("FAIL relock_run: clkstart %0d state %0d retry %0d expected 1 %0d 0",
               ClkStart, State, Retry_Cnt, S_RUN);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Lock never arrives: WAIT_LOCK timeout MAXR times in a row -> LOCKOUT.
  task automatic test_lockout();
    Enable = 1'b0;
    step(1);
    n_checks++;
    if ({ClkStart, State} !== {1'b0, S_IDLE}) begin
      n_errors++; $display("FAIL disable_idle: clkstart %0d state %0d expected 0 %0d", ClkStart, State, S_IDLE);
    end
    PLL_Lock = 1'b0;
    step(3);
    Enable = 1'b1;
    step(1);
    n_checks++;
    if (State !== S_WAIT) begin
      n_errors++; $display("FAIL tmo_wait_entry: state %0d expected %0d", State, S_WAIT);
    end
    for (int i = 1; i <= int'(MAXR); i++) begin
      step(TMO - 1);
      n_checks++;
      if (State !== S_WAIT) begin
        n_errors++; $display("FAIL tmo_early_%0d: state %0d expected %0d", i, State, S_WAIT);
      end
      step(1);
      exp_retry = bump_retry(exp_retry);
      n_checks++;
      if ({State, Clk_Fault, Retry_Cnt} !== {S_FAULT, 1'b1, 3'(exp_retry)}) begin
        n_errors++;
        $display("FAIL tmo_fault_%0d: state %0d fault %0d retry %0d expected %0d 1 %0d",
                 i, State, Clk_Fault, Retry_Cnt, S_FAULT, exp_retry);
      end
      if (i < int'(MAXR)) begin
        step(HOLD);
        n_checks++;
        if (State !== S_WAIT) begin
          n_errors++; $display("FAIL tmo_retry_%0d: state %0d expected %0d", i, State, S_WAIT);
        end
      end
    end
    step(1);
    n_checks++;
    if ({State, Lockout, ClkStart, Retry_Cnt} !== {S_LOCK, 1'b1, 1'b0, 3'(MAXR)}) begin
      n_errors++;
      $display("FAIL lockout_entry: state %0d lockout %0d clkstart %0d retry %0d expected %0d 1 0 %0d",
               State, Lockout, ClkStart, Retry_Cnt, S_LOCK, MAXR);
    end
    PLL_Lock = 1'b1;
    step(40);
    n_checks++;
    if ({State, Lockout} !== {S_LOCK, 1'b1}) begin
      n_errors++; $display("FAIL lockout_hold: state %0d lockout %0d expected %0d 1", State, Lockout, S_LOCK);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Force_Std out of LOCKOUT, then out of RUN.
  task automatic test_force_std();
    Force_Std = 1'b1;
    step(1);
    Force_Std = 1'b0;
    exp_retry = 0;
    n_checks++;
    if ({State, Lockout, Retry_Cnt, ClkStart} !== {S_IDLE, 1'b0, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL force_from_lockout: state %0d lockout %0d retry %0d clkstart %0d expected %0d 0 0 0",
               State, Lockout, Retry_Cnt, ClkStart, S_IDLE);
    end
    step(1);
    n_checks++;
    if (State !== S_WAIT) begin
      n_errors++; $display("FAIL force_then_wait: state %0d expected %0d", State, S_WAIT);
    end
    step(1 + LAT);  // lock already synchronized: SETTLE next edge
    n_checks++;
    if ({State, ClkStart} !== {S_RUN, 1'b1}) begin
      n_errors++; $display("FAIL force_rerun: state %0d clkstart %0d expected %0d 1", State, ClkStart, S_RUN);
    end
    step($urandom_range(1, 30));
    Force_Std = 1'b1;
    step(1);
    Force_Std = 1'b0;
    n_checks++;
    if ({State, ClkStart} !== {S_IDLE, 1'b0}) begin
      n_errors++; $display("FAIL force_from_run: state %0d clkstart %0d expected %0d 0", State, ClkStart, S_IDLE);
    end
  endtask

`ifdef EPLL_FREQ_CHECK_EN
  // Edges per window are bracketed by the shortest (WIN-1 cycles) and the
  // longest (WIN cycles plus one boundary edge) sampling spans.
  function automatic int edges_lo(input int half_ns);
    return ((int'(WIN) - 1) * 10) / (2 * half_ns);
  endfunction
  function automatic int edges_hi(input int half_ns);
    return (int'(WIN) * 10) / (2 * half_ns) + 1;
  endfunction

  task automatic test_freq_check();
    int half;
    int n;
    Force_Std = 1'b1; Enable = 1'b0;
    step(1);
    Force_Std = 1'b0;
    exp_retry = 0;
    half = $urandom_range(65, 80);
    ref_half_ns = half;
    step(4);
    Enable = 1'b1;
    step(2 + SETTLE);
    n_checks++;
    if (State !== S_CHECK) begin
      n_errors++; $display("FAIL check_entry: state %0d expected %0d", State, S_CHECK);
    end
    step(WIN - 1);
    n_checks++;
    if (State !== S_CHECK) begin
      n_errors++; $display("FAIL check_window_early: state %0d expected %0d", State, S_CHECK);
    end
    step(1);
    exp_retry = bump_retry(exp_retry);
    n_checks++;
    if ((edges_hi(half) < int'(CMIN)) && ({State, Retry_Cnt} !== {S_FAULT, 3'(exp_retry)})) begin
      n_errors++;
      $display("FAIL slow_ref_fault: state %0d retry %0d expected %0d %0d (half %0d ns)",
               State, Retry_Cnt, S_FAULT, exp_retry, half);
    end
    half = $urandom_range(49, 51);
    ref_half_ns = half;
    step(HOLD + 1 + SETTLE + WIN - 1);
    n_checks++;
    if (ClkStart !== 1'b0) begin
      n_errors++; $display("FAIL good_ref_early: clkstart %0d expected 0", ClkStart);
    end
    step(1);
    exp_retry = 0;
    n_checks++;
    if ((edges_lo(half) >= int'(CMIN)) && (edges_hi(half) <= int'(CMAX)) &&
        ({State, ClkStart, Retry_Cnt} !== {S_RUN, 1'b1, 3'd0})) begin
      n_errors++;
      $display("FAIL good_ref_run: state %0d clkstart %0d retry %0d expected %0d 1 0 (half %0d ns)",
               State, ClkStart, Retry_Cnt, S_RUN, half);
    end
    half = $urandom_range(30, 38);
    ref_half_ns = half;
    n = 0;
    while ((State !== S_FAULT) && (n < 3 * int'(WIN) + 10)) begin
      step(1);
      n++;
    end
    exp_retry = bump_retry(exp_retry);
    n_checks++;
    if ((edges_lo(half) > int'(CMAX)) && ({State, ClkStart, Retry_Cnt} !== {S_FAULT, 1'b0, 3'(exp_retry)})) begin
      n_errors++;
      $display("FAIL fast_ref_fault: state %0d clkstart %0d retry %0d after %0d cycles expected %0d 0 %0d",
               State, ClkStart, Retry_Cnt, n, S_FAULT, exp_retry);
    end
    ref_half_ns = 50;
    step(4);
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Asynchronous reset in SETTLE and in the first FAULT cycle.
  task automatic test_reset_mid();
    Enable = 1'b1; PLL_Lock = 1'b1;
    Force_Std = 1'b1;
    step(1);
    Force_Std = 1'b0;
    step(2);
    step($urandom_range(1, SETTLE - 3));
    n_checks++;
    if (State !== S_SETTLE) begin
      n_errors++; $display("FAIL mid_settle: state %0d expected %0d", State, S_SETTLE);
    end
    #3 SYS_START = 1'b0;
    #1;
    n_checks++;
    if ({ClkStart, Clk_Fault, Lockout, Retry_Cnt, State} !== 9'd0) begin
      n_errors++;
      $display("FAIL async_reset_settle: got %b expected 000000000",
               {ClkStart, Clk_Fault, Lockout, Retry_Cnt, State});
    end
    step(2);
    SYS_START = 1'b1;
    step(RUN_DLY - 1);
    n_checks++;
    if (ClkStart !== 1'b0) begin
      n_errors++; $display("FAIL restart_early: clkstart %0d expected 0", ClkStart);
    end
    step(1);
    n_checks++;
    if ({ClkStart, State} !== {1'b1, S_RUN}) begin
      n_errors++; $display("FAIL restart_run: clkstart %0d state %0d expected 1 %0d", ClkStart, State, S_RUN);
    end
    PLL_Lock = 1'b0;
    step(3);
    n_checks++;
    if ({Clk_Fault, Retry_Cnt, State} !== {1'b1, 3'd1, S_FAULT}) begin
      n_errors++;
      $display("FAIL prereset_fault: fault %0d retry %0d state %0d expected 1 1 %0d",
               Clk_Fault, Retry_Cnt, State, S_FAULT);
    end
    #3 SYS_START = 1'b0;
    #1;
    n_checks++;
    if ({ClkStart, Clk_Fault, Lockout, Retry_Cnt, State} !== 9'd0) begin
      n_errors++;
      $display("FAIL async_reset_fault: got %b expected 000000000",
               {ClkStart, Clk_Fault, Lockout, Retry_Cnt, State});
    end
    step(2);
    SYS_START = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    for (int k = 0; k < 3; k++) test_lock_drop();
    test_lockout();
    test_force_std();
`ifdef EPLL_FREQ_CHECK_EN
    test_freq_check();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
